// File: rtl/pq_arbiter.sv
// Two-port round-robin arbiter and sequencer for the shared priority-queue core.
// Grants one requester at a time, issues a single strobe, then waits for pq_done under a watchdog.
module pq_arbiter #(
  parameter int W       = 16,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic         op0,
  input  logic         op1,
  input  logic [W-1:0] wdata0,
  input  logic [W-1:0] wdata1,
  output logic         ack0,
  output logic         ack1,
  output logic         err,
  output logic [W-1:0] rdata,
  output logic         pq_insert,
  output logic         pq_remove,
  output logic [W-1:0] pq_din,
  input  logic [W-1:0] pq_dout,
  input  logic         pq_done,
  input  logic         pq_full,
  input  logic         pq_empty,
  output logic [1:0]   gnt,
  output logic         timeout_flag
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic          last;      // requester granted most recently
  logic          owner;
  logic          op_q;
  logic [CW-1:0] wd_cnt;

  logic         any_req;
  logic         pick;
  logic         sel_op;
  logic [W-1:0] sel_wdata;
  logic         reject;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    any_req   = req0 | req1;
    pick      = 1'b0;
    if (req0 && req1) pick = ~last;
    else if (req1)    pick = 1'b1;
    sel_op    = pick ? op1 : op0;
    sel_wdata = pick ? wdata1 : wdata0;
    reject    = sel_op ? pq_empty : pq_full;
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would
  // make later reads in this block see the new value and break the register model.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last         <= 1'b1;
      owner        <= 1'b0;
      op_q         <= 1'b0;
      wd_cnt       <= '0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      err          <= 1'b0;
      rdata        <= '0;
      pq_insert    <= 1'b0;
      pq_remove    <= 1'b0;
      pq_din       <= '0;
      gnt          <= 2'b00;
      timeout_flag <= 1'b0;
    end else begin
      // Pulses default low so each is high for exactly the one cycle it is set.
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      pq_insert <= 1'b0;
      pq_remove <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            owner <= pick;
            op_q  <= sel_op;
            last  <= pick;
            gnt   <= pick ? 2'b10 : 2'b01;
            if (reject) begin
              err   <= 1'b1;
              rdata <= '0;
              ack0  <= ~pick;
              ack1  <= pick;
              state <= RESP;
            end else begin
              pq_insert <= ~sel_op;
              pq_remove <= sel_op;
              pq_din    <= sel_wdata;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          wd_cnt <= '0;
          pq_din <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          // A completion on the limit cycle still wins over the watchdog.
          if (pq_done) begin
            rdata <= op_q ? pq_dout : '0;
            err   <= 1'b0;
            ack0  <= ~owner;
            ack1  <= owner;
            state <= RESP;
          end else if (wd_cnt == CW'(TIMEOUT)) begin
            rdata        <= '0;
            err          <= 1'b1;
            timeout_flag <= 1'b1;
            ack0         <= ~owner;
            ack1         <= owner;
            state        <= RESP;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        RESP: begin
          err   <= 1'b0;
          rdata <= '0;
          gnt   <= 2'b00;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pq_arbiter.sv
// Scoreboard bench for pq_arbiter: directed requests push expected commands/acks,
// a negedge monitor pops and compares, and a small core model answers strobes.
module tb_pq_arbiter;

  localparam int W  = 16;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
  logic [W-1:0] wdata0 = '0, wdata1 = '0;
  logic         ack0, ack1, err;
  logic [W-1:0] rdata, pq_din;
  logic         pq_insert, pq_remove;
  logic [W-1:0] pq_dout = '0;
  logic         pq_done = 1'b0, pq_full = 1'b0, pq_empty = 1'b0;
  logic [1:0]   gnt;
  logic         timeout_flag;

  pq_arbiter #(.W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata),
    .pq_insert(pq_insert), .pq_remove(pq_remove), .pq_din(pq_din),
    .pq_dout(pq_dout), .pq_done(pq_done), .pq_full(pq_full), .pq_empty(pq_empty),
    .gnt(gnt), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  typedef struct {int port; logic err; logic [W-1:0] rdata; int lat; bit from_req;} resp_t;
  typedef struct {bit remove; logic [W-1:0] din; int port;} cmd_t;

  resp_t exp_q[$];
  cmd_t  cmd_q[$];
  resp_t mr;
  cmd_t  mc;

  int checks = 0, errors = 0;
  int cyc = 0, strobe_cyc = 0, req_cyc = 0;
  int done_delay = 0, cd = 0;
  logic [W-1:0] rem_val = '0;
  bit prev_strobe = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int p);
    return (p != 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic exp_resp(input int port, input logic e, input logic [W-1:0] rd,
                          input int lat, input bit from_req);
    resp_t r;
    r.port = port; r.err = e; r.rdata = rd; r.lat = lat; r.from_req = from_req;
    exp_q.push_back(r);
  endtask

  task automatic exp_cmd(input bit rm, input logic [W-1:0] din, input int port);
    cmd_t c;
    c.remove = rm; c.din = din; c.port = port;
    cmd_q.push_back(c);
  endtask

  task automatic wait_ack(input int p);
    bit got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = (p != 0) ? ack1 : ack0;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_wait: port %0d got no ack, required one within 100 cycles", p);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Queue core model: pulses pq_done done_delay negedges after a strobe (0 = never).
  always @(negedge clk) begin
    pq_done = 1'b0;
    pq_dout = '0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        pq_done = 1'b1;
        pq_dout = rem_val;
      end
    end
    if (pq_insert || pq_remove) cd = done_delay;
  end

  // Monitor: compares every strobe and every ack against the scoreboard queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pq_insert || pq_remove) begin
        check("strobe_overlap", pq_insert & pq_remove, 0);
        check("strobe_back_to_back", prev_strobe, 0);
        if (cmd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe: ins %0b rem %0b, required none", pq_insert, pq_remove);
        end else begin
          mc = cmd_q.pop_front();
          check("strobe_op", pq_remove, mc.remove);
          if (!mc.remove) check("strobe_din", pq_din, mc.din);
          check("strobe_gnt", gnt, oh(mc.port));
        end
        strobe_cyc = cyc;
      end
      prev_strobe = pq_insert || pq_remove;
      if (ack0 || ack1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: acks %b, required none", {ack1, ack0});
        end else begin
          mr = exp_q.pop_front();
          check("ack_port", {ack1, ack0}, oh(mr.port));
          check("ack_err", err, mr.err);
          check("ack_rdata", rdata, mr.rdata);
          check("ack_gnt", gnt, oh(mr.port));
          if (mr.lat >= 0)
            check("ack_latency", cyc - (mr.from_req ? req_cyc : strobe_cyc), mr.lat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {ack0, ack1, err, pq_insert, pq_remove, gnt, timeout_flag}, 0);
    check("reset_rdata", rdata, 0);
    check("reset_din", pq_din, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single insert, core answers 4 cycles after the strobe.
    done_delay = 4;
    exp_cmd(1'b0, 16'h3A05, 0);
    exp_resp(0, 1'b0, 16'h0000, 5, 1'b0);
    op0 = 1'b0; wdata0 = 16'h3A05; req0 = 1'b1; req_cyc = cyc;
    wait_ack(0);
    req0 = 1'b0;
    repeat (2) @(negedge clk);

    // Remove on port 1 returning data.
    done_delay = 3; rem_val = 16'h7F11;
    exp_cmd(1'b1, 16'h0000, 1);
    exp_resp(1, 1'b0, 16'h7F11, 4, 1'b0);
    op1 = 1'b1; wdata1 = '0; req1 = 1'b1;
    wait_ack(1);
    req1 = 1'b0; op1 = 1'b0;
    repeat (2) @(negedge clk);

    // Sustained contention: grants alternate 0,1,0,1.
    done_delay = 2; rem_val = '0;
    exp_cmd(1'b0, 16'hA100, 0); exp_resp(0, 1'b0, 16'h0000, -1, 1'b0);
    exp_cmd(1'b0, 16'hB200, 1); exp_resp(1, 1'b0, 16'h0000, -1, 1'b0);
    exp_cmd(1'b0, 16'hA101, 0); exp_resp(0, 1'b0, 16'h0000, -1, 1'b0);
    exp_cmd(1'b0, 16'hB201, 1); exp_resp(1, 1'b0, 16'h0000, -1, 1'b0);
    fork
      begin
        op0 = 1'b0; wdata0 = 16'hA100; req0 = 1'b1;
        wait_ack(0);
        wdata0 = 16'hA101;
        wait_ack(0);
        req0 = 1'b0;
      end
      begin
        op1 = 1'b0; wdata1 = 16'hB200; req1 = 1'b1;
        wait_ack(1);
        wdata1 = 16'hB201;
        wait_ack(1);
        req1 = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    check("tflag_before_timeout", timeout_flag, 0);

    // Rejections: insert while full, remove while empty.
    pq_full = 1'b1;
    exp_resp(0, 1'b1, 16'h0000, 1, 1'b1);
    op0 = 1'b0; wdata0 = 16'h5555; req0 = 1'b1; req_cyc = cyc;
    wait_ack(0);
    req0 = 1'b0; pq_full = 1'b0;
    repeat (2) @(negedge clk);
    pq_empty = 1'b1;
    exp_resp(1, 1'b1, 16'h0000, 1, 1'b1);
    op1 = 1'b1; req1 = 1'b1; req_cyc = cyc;
    wait_ack(1);
    req1 = 1'b0; op1 = 1'b0; pq_empty = 1'b0;
    repeat (2) @(negedge clk);

    // Watchdog: core never answers, ack TO+2 cycles after the strobe.
    done_delay = 0;
    exp_cmd(1'b0, 16'h1234, 0);
    exp_resp(0, 1'b1, 16'h0000, TO + 2, 1'b0);
    op0 = 1'b0; wdata0 = 16'h1234; req0 = 1'b1;
    wait_ack(0);
    req0 = 1'b0;
    check("tflag_after_timeout", timeout_flag, 1);
    repeat (2) @(negedge clk);

    // Minimum-latency remove after the timeout; sticky flag stays set.
    done_delay = 1; rem_val = 16'h0042;
    exp_cmd(1'b1, 16'h0000, 1);
    exp_resp(1, 1'b0, 16'h0042, 2, 1'b0);
    op1 = 1'b1; req1 = 1'b1;
    wait_ack(1);
    req1 = 1'b0; op1 = 1'b0;
    repeat (2) @(negedge clk);
    check("tflag_sticky", timeout_flag, 1);

    // Reset during WAIT: outputs clear at once, no ack, next tie goes to port 0.
    done_delay = 0; rem_val = '0;
    exp_cmd(1'b0, 16'hBEEF, 0);
    op0 = 1'b0; wdata0 = 16'hBEEF; req0 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = pq_insert;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL strobe_wait: no pq_insert within 20 cycles, required one");
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_ctrl", {ack0, ack1, err, pq_insert, pq_remove, gnt, timeout_flag}, 0);
    check("midreset_rdata", rdata, 0);
    check("midreset_din", pq_din, 0);
    @(negedge clk);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    done_delay = 2;
    exp_cmd(1'b0, 16'hC000, 0); exp_resp(0, 1'b0, 16'h0000, -1, 1'b0);
    exp_cmd(1'b0, 16'hC111, 1); exp_resp(1, 1'b0, 16'h0000, -1, 1'b0);
    op0 = 1'b0; op1 = 1'b0; wdata0 = 16'hC000; wdata1 = 16'hC111;
    req0 = 1'b1; req1 = 1'b1;
    fork
      begin wait_ack(0); req0 = 1'b0; end
      begin wait_ack(1); req1 = 1'b0; end
    join

    repeat (5) @(negedge clk);
    check("resp_queue_drained", exp_q.size(), 0);
    check("cmd_queue_drained", cmd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
